// File: rtl/dll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dll_pkg                                                      |
// | Description : Shared types and default constants for the DLL loop control. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package dll_pkg;

    localparam int DEF_CODE_W   = 6;
    localparam int DEF_FILT_TH  = 4;
    localparam int DEF_SETTLE   = 3;
    localparam int DEF_LOCK_REV = 4;

    // ST_ prefix keeps the SETTLE state distinct from the SETTLE parameter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage : dll_pkg
`default_nettype wire

// File: rtl/dll_vote_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dll_vote_filter                                              |
// | Description : Signed majority-vote accumulator; strobes step_up/step_dn     |
// |               combinationally on the sample that reaches +/-FILT_TH.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dll_vote_filter
    import dll_pkg::*;
#(
    parameter int FILT_TH = DEF_FILT_TH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic vote_valid,
    input  logic vote_late,
    output logic step_up,
    output logic step_dn
);

    localparam int ACC_W = $clog2(FILT_TH) + 2;
    localparam logic signed [ACC_W-1:0] ONE    = 1;
    localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] w_acc_next;

    always_comb begin
        w_acc_next = vote_late ? (acc_q - ONE) : (acc_q + ONE);
        step_up    = vote_valid && !clr && (w_acc_next == TH_POS);
        step_dn    = vote_valid && !clr && (w_acc_next == TH_NEG);
        acc_d      = acc_q;
        // A threshold hit consumes the votes, so |acc| never exceeds FILT_TH-1.
        if (clr || step_up || step_dn) begin
            acc_d = '0;
        end else if (vote_valid) begin
            acc_d = w_acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : dll_vote_filter
`default_nettype wire

// File: rtl/dll_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dll_loop_ctrl                                                |
// | Description : DLL digital loop controller: filtered code stepping with     |
// |               settle blanking, lock and saturation reporting.              |
// |               Optional manual override enabled by DLL_CTRL_OVERRIDE_EN.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dll_loop_ctrl
    import dll_pkg::*;
#(
    parameter int CODE_W    = DEF_CODE_W,
    parameter int CODE_INIT = 2 ** (CODE_W - 1),
    parameter int FILT_TH   = DEF_FILT_TH,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int LOCK_REV  = DEF_LOCK_REV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pd_valid,
    input  logic              pd_late,
`ifdef DLL_CTRL_OVERRIDE_EN
    input  logic              ovr_en,
    input  logic [CODE_W-1:0] ovr_code,
`endif
    output logic [CODE_W-1:0] code_o,
    output logic              code_step_o,
    output logic              locked_o,
    output logic              sat_o
);

    localparam int REV_W = $clog2(LOCK_REV + 1);
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CODE_W-1:0] CODE_MAX   = '1;
    localparam logic [CODE_W-1:0] CODE_RST   = CODE_W'(CODE_INIT);
    localparam logic [REV_W-1:0]  LOCK_MAX   = REV_W'(LOCK_REV);
    localparam logic [CNT_W-1:0]  SETTLE_LD  = CNT_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                code_step_q, code_step_d;
    logic                locked_q, locked_d;
    logic                sat_q, sat_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic                has_dir_q, has_dir_d;

    logic                w_ovr;
    logic [CODE_W-1:0]   w_ovr_code;
    logic                w_tracking;
    logic                w_step_up;
    logic                w_step_dn;
    logic                w_step_req;
    logic                w_at_limit;
    dir_e                w_step_dir;

`ifdef DLL_CTRL_OVERRIDE_EN
    assign w_ovr      = ovr_en;
    assign w_ovr_code = ovr_code;
`else
    assign w_ovr      = 1'b0;
    assign w_ovr_code = '0;
`endif

    // Votes only count in TRACK; the en 0->1 edge and SETTLE are blanked here.
    assign w_tracking = en && !w_ovr && (state_q == ST_TRACK);

    dll_vote_filter #(
        .FILT_TH    (FILT_TH)
    ) u_vote_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!w_tracking),
        .vote_valid (w_tracking && pd_valid),
        .vote_late  (pd_late),
        .step_up    (w_step_up),
        .step_dn    (w_step_dn)
    );

    assign w_step_req = w_step_up || w_step_dn;
    assign w_step_dir = w_step_up ? DIR_UP : DIR_DN;
    assign w_at_limit = (w_step_up && (code_q == CODE_MAX)) ||
                        (w_step_dn && (code_q == '0));

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        code_step_d = 1'b0;
        sat_d       = sat_q;
        rev_d       = rev_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        has_dir_d   = has_dir_q;
        if (w_ovr) begin
            state_d     = ST_IDLE;
            code_d      = w_ovr_code;
            code_step_d = (w_ovr_code != code_q);
            rev_d       = '0;
            has_dir_d   = 1'b0;
        end else if (!en) begin
            state_d   = ST_IDLE;
            rev_d     = '0;
            has_dir_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_step_req) begin
                        if (w_at_limit) begin
                            sat_d = 1'b1;
                            rev_d = '0;
                        end else begin
                            code_d      = w_step_up ? (code_q + CODE_W'(1)) : (code_q - CODE_W'(1));
                            code_step_d = 1'b1;
                            sat_d       = 1'b0;
                            state_d     = ST_SETTLE;
                            cnt_d       = SETTLE_LD;
                            // Reversals are only counted once a reference direction exists.
                            if (has_dir_q) begin
                                if (dir_q != w_step_dir) begin
                                    rev_d = (rev_q == LOCK_MAX) ? rev_q : (rev_q + REV_W'(1));
                                end else begin
                                    rev_d = '0;
                                end
                            end
                            dir_d     = w_step_dir;
                            has_dir_d = 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_TRACK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (rev_d == LOCK_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= CODE_RST;
            code_step_q <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
            rev_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            has_dir_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            code_step_q <= code_step_d;
            locked_q    <= locked_d;
            sat_q       <= sat_d;
            rev_q       <= rev_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            has_dir_q   <= has_dir_d;
        end
    end

    assign code_o      = code_q;
    assign code_step_o = code_step_q;
    assign locked_o    = locked_q;
    assign sat_o       = sat_q;

endmodule : dll_loop_ctrl
`default_nettype wire
